// File: rtl/fetch_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pipe
// Description : Instruction fetch stage with IF/ID register, redirect, HALT detect
// Revision    : 1.0
// ============================================================================
module fetch_unit_pipe #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] HALT_WORD = '1,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_f,
   input  logic              stall_d,
   input  logic              flush_d,
   input  logic              pc_src_e,
   input  logic [DATA_W-1:0] branch_target_e,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] imem_addr,
   output logic [DATA_W-1:0] instr_d,
   output logic [DATA_W-1:0] pc_d,
   output logic [DATA_W-1:0] pc_plus4_d,
   output logic              valid_d,
   output logic              halted,
   output logic [CNT_W-1:0]  fetch_count
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [DATA_W-1:0] c_four      = DATA_W'(4);
   localparam logic [DATA_W-1:0] c_word_mask = ~DATA_W'(3);
   localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

   state_t              r_state;
   logic [DATA_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_instr;
   logic [DATA_W-1:0]   r_pc_d;
   logic [DATA_W-1:0]   r_pc_plus4_d;
   logic                r_valid;
   logic                r_halted;
   logic [CNT_W-1:0]    r_count;

   logic [DATA_W-1:0]   w_pc_plus4;
   logic [DATA_W-1:0]   w_target;
   logic                w_is_halt;
   logic                w_in_run;
   logic                w_redirect;
   logic                w_halt_accept;
   logic                w_load;
   logic                w_bubble;

   assign w_pc_plus4    = r_pc + c_four;
   assign w_target      = branch_target_e & c_word_mask;
   assign w_is_halt     = (imem_rdata == HALT_WORD);
   assign w_in_run      = (r_state == S_RUN);
   assign w_redirect    = pc_src_e && (r_state != S_BOOT);
   assign w_halt_accept = w_in_run && w_is_halt && !pc_src_e && !flush_d && !stall_d && !stall_f;
   // A real word enters IF/ID only when nothing kills, holds or bubbles it.
   assign w_load        = !flush_d && !pc_src_e && !stall_d && w_in_run && !w_is_halt;
   assign w_bubble      = flush_d || pc_src_e || (!stall_d && !w_load);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_BOOT;
         r_halted     <= 1'b0;
         r_pc         <= RESET_PC;
         r_instr      <= '0;
         r_pc_d       <= '0;
         r_pc_plus4_d <= '0;
         r_valid      <= 1'b0;
         r_count      <= '0;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state  <= S_RUN;
               r_halted <= 1'b0;
            end
            S_RUN: begin
               if (w_halt_accept) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end
            end
            S_HALT: begin
               if (pc_src_e) begin
                  r_state  <= S_RUN;
                  r_halted <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_BOOT;
               r_halted <= 1'b0;
            end
         endcase

         if (w_redirect) begin
            r_pc <= w_target;
         end else if (!stall_f && w_in_run && !w_halt_accept) begin
            r_pc <= w_pc_plus4;
         end

         if (w_bubble) begin
            r_instr      <= '0;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid      <= 1'b0;
         end else if (w_load) begin
            r_instr      <= imem_rdata;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid      <= 1'b1;
         end

         if (w_load && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign imem_addr   = r_pc;
   assign instr_d     = r_instr;
   assign pc_d        = r_pc_d;
   assign pc_plus4_d  = r_pc_plus4_d;
   assign valid_d     = r_valid;
   assign halted      = r_halted;
   assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit_pipe
// Description : Directed and randomized checks of fetch_unit_pipe against a behavioural model
// Revision    : 1.0
// ============================================================================
module tb_fetch_unit_pipe;

   localparam logic [31:0] c_halt = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n, stall_f, stall_d, flush_d, pc_src_e;
   logic [31:0] branch_target_e;
   logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d;
   logic        valid_d, halted;
   logic [15:0] fetch_count;
   logic [31:0] imem_addr_s, imem_rdata_s, instr_d_s, pc_d_s, pc_plus4_d_s;
   logic        valid_d_s, halted_s;
   logic [1:0]  fetch_count_s;

   logic [31:0] rom [0:255];
   assign imem_rdata   = rom[imem_addr[9:2]];
   assign imem_rdata_s = rom[imem_addr_s[9:2]];

   int checks = 0;
   int errors = 0;

   // Behavioural model of the architected state.
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
   bit          m_valid, m_boot, m_halt;
   int          m_cnt;

   always #5 clk = ~clk;

   fetch_unit_pipe dut (
      .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
      .pc_src_e(pc_src_e), .branch_target_e(branch_target_e), .imem_rdata(imem_rdata),
      .imem_addr(imem_addr), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .valid_d(valid_d), .halted(halted), .fetch_count(fetch_count)
   );

   fetch_unit_pipe #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
      .pc_src_e(pc_src_e), .branch_target_e(branch_target_e), .imem_rdata(imem_rdata_s),
      .imem_addr(imem_addr_s), .instr_d(instr_d_s), .pc_d(pc_d_s), .pc_plus4_d(pc_plus4_d_s),
      .valid_d(valid_d_s), .halted(halted_s), .fetch_count(fetch_count_s)
   );

   function automatic logic [15:0] exp_cnt16();
      return (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0];
   endfunction

   function automatic logic [1:0] exp_cnt2();
      return (m_cnt > 3) ? 2'd3 : m_cnt[1:0];
   endfunction

   // Advance one clock; the model applies the fetch rules to its own PC and ROM view.
   task automatic tick();
      logic [31:0] word, n_pc, n_instr, n_pcd, n_pc4;
      bit          n_valid, n_boot, n_halt, accept, run;
      int          n_cnt;
      word    = rom[m_pc[9:2]];
      run     = !m_boot && !m_halt;
      n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd; n_pc4 = m_pc4;
      n_valid = m_valid; n_boot = m_boot; n_halt = m_halt; n_cnt = m_cnt;
      if (!rst_n) begin
         n_pc = 0; n_instr = 0; n_pcd = 0; n_pc4 = 0; n_valid = 0;
         n_boot = 1; n_halt = 0; n_cnt = 0;
      end else begin
         accept = run && word == c_halt && !pc_src_e && !flush_d && !stall_d && !stall_f;
         if (pc_src_e && !m_boot)               n_pc = {branch_target_e[31:2], 2'b00};
         else if (stall_f || !run || accept)    n_pc = m_pc;
         else                                   n_pc = m_pc + 32'd4;
         if (flush_d || pc_src_e) begin
            n_instr = 0; n_pcd = 0; n_pc4 = 0; n_valid = 0;
         end else if (stall_d) begin
            n_valid = m_valid;
         end else if (!run || word == c_halt) begin
            n_instr = 0; n_pcd = 0; n_pc4 = 0; n_valid = 0;
         end else begin
            n_instr = word; n_pcd = m_pc; n_pc4 = m_pc + 32'd4; n_valid = 1; n_cnt = m_cnt + 1;
         end
         if (m_boot)                 begin n_boot = 0; n_halt = 0; end
         else if (accept)            n_halt = 1;
         else if (m_halt && pc_src_e) n_halt = 0;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pc4 = n_pc4;
      m_valid = n_valid; m_boot = n_boot; m_halt = n_halt; m_cnt = n_cnt;
   endtask

   task automatic idle_inputs();
      stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; branch_target_e = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; idle_inputs();
      tick();
      checks++;
      if (imem_addr !== 32'h0 || instr_d !== 32'h0 || pc_d !== 32'h0 || pc_plus4_d !== 32'h0 ||
          valid_d !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'h0) begin
         errors++;
         $display("FAIL reset: addr=%h instr=%h pc_d=%h pc4=%h valid=%b halted=%b cnt=%0d, required all zero",
                  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted, fetch_count);
      end
   endtask

   task automatic test_startup();
      logic [31:0] exp_addr [0:2];
      logic        exp_valid [0:2];
      exp_addr  = '{32'h0, 32'h4, 32'h8};
      exp_valid = '{1'b0, 1'b1, 1'b1};
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (imem_addr !== exp_addr[i] || valid_d !== exp_valid[i]) begin
            errors++;
            $display("FAIL startup[%0d]: addr=%h valid=%b, required addr=%h valid=%b",
                     i, imem_addr, valid_d, exp_addr[i], exp_valid[i]);
         end
         if (i == 1) begin
            checks++;
            if (instr_d !== 32'h1 || pc_d !== 32'h0 || pc_plus4_d !== 32'h4) begin
               errors++;
               $display("FAIL first_word: instr=%h pc_d=%h pc4=%h, required 1/0/4", instr_d, pc_d, pc_plus4_d);
            end
         end
      end
   endtask

   task automatic test_stall();
      stall_f = 1; stall_d = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (imem_addr !== 32'h8 || instr_d !== 32'h2 || pc_d !== 32'h4 || fetch_count !== 16'd2) begin
            errors++;
            $display("FAIL stall[%0d]: addr=%h instr=%h pc_d=%h cnt=%0d, required 8/2/4/2",
                     i, imem_addr, instr_d, pc_d, fetch_count);
         end
      end
      idle_inputs();
      tick();
      checks++;
      if (imem_addr !== 32'hC || instr_d !== 32'h3 || fetch_count !== 16'd3) begin
         errors++;
         $display("FAIL stall_resume: addr=%h instr=%h cnt=%0d, required c/3/3", imem_addr, instr_d, fetch_count);
      end
   endtask

   task automatic test_redirect();
      pc_src_e = 1; branch_target_e = 32'h43; stall_f = 1;
      tick();
      checks++;
      if (imem_addr !== 32'h40 || valid_d !== 1'b0 || instr_d !== 32'h0) begin
         errors++;
         $display("FAIL redirect: addr=%h valid=%b instr=%h, required 40/0/0", imem_addr, valid_d, instr_d);
      end
      idle_inputs();
      tick();
      checks++;
      if (instr_d !== rom[16] || pc_d !== 32'h40 || valid_d !== 1'b1 || imem_addr !== 32'h44) begin
         errors++;
         $display("FAIL redirect_fetch: instr=%h pc_d=%h valid=%b addr=%h, required %h/40/1/44",
                  instr_d, pc_d, valid_d, imem_addr, rom[16]);
      end
   endtask

   task automatic test_halt();
      logic [31:0] saved;
      saved = rom[3]; rom[3] = c_halt;
      pc_src_e = 1; branch_target_e = 32'hC;
      tick();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (halted !== 1'b1 || imem_addr !== 32'hC || valid_d !== 1'b0) begin
            errors++;
            $display("FAIL halt[%0d]: halted=%b addr=%h valid=%b, required 1/c/0", i, halted, imem_addr, valid_d);
         end
      end
      pc_src_e = 1; branch_target_e = 32'h20;
      tick();
      checks++;
      if (halted !== 1'b0 || imem_addr !== 32'h20) begin
         errors++;
         $display("FAIL halt_exit: halted=%b addr=%h, required 0/20", halted, imem_addr);
      end
      idle_inputs();
      tick();
      checks++;
      if (instr_d !== rom[8] || valid_d !== 1'b1) begin
         errors++;
         $display("FAIL halt_resume: instr=%h valid=%b, required %h/1", instr_d, valid_d, rom[8]);
      end
      rom[3] = saved;
   endtask

   task automatic test_flush_wrap();
      flush_d = 1; stall_d = 1;
      tick();
      checks++;
      if (valid_d !== 1'b0 || instr_d !== 32'h0 || pc_d !== 32'h0) begin
         errors++;
         $display("FAIL flush_stall: valid=%b instr=%h pc_d=%h, required bubble", valid_d, instr_d, pc_d);
      end
      idle_inputs();
      pc_src_e = 1; branch_target_e = 32'hFFFF_FFFE;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (imem_addr !== 32'h0 || pc_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'h0 || instr_d !== rom[255]) begin
         errors++;
         $display("FAIL wrap: addr=%h pc_d=%h pc4=%h instr=%h, required 0/fffffffc/0/%h",
                  imem_addr, pc_d, pc_plus4_d, instr_d, rom[255]);
      end
   endtask

   task automatic test_saturate();
      rst_n = 0; idle_inputs();
      tick();
      rst_n = 1;
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (fetch_count_s !== 2'd3 || fetch_count !== 16'd6) begin
         errors++;
         $display("FAIL saturate: small=%0d big=%0d, required 3/6", fetch_count_s, fetch_count);
      end
      stall_f = 1; stall_d = 1; rst_n = 0;
      tick();
      checks++;
      if (imem_addr !== 32'h0 || valid_d !== 1'b0 || instr_d !== 32'h0 || fetch_count !== 16'h0 ||
          fetch_count_s !== 2'd0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: addr=%h valid=%b instr=%h cnt=%0d cnt_s=%0d halted=%b, required zeros",
                  imem_addr, valid_d, instr_d, fetch_count, fetch_count_s, halted);
      end
      rst_n = 1; idle_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 256; i++)
         rom[i] = ($urandom_range(0, 11) == 0) ? c_halt : $urandom;
      for (int i = 0; i < 3000; i++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         stall_f  = ($urandom_range(0, 4) == 0);
         stall_d  = ($urandom_range(0, 4) == 0);
         flush_d  = ($urandom_range(0, 9) == 0);
         pc_src_e = ($urandom_range(0, 7) == 0);
         branch_target_e = $urandom;
         tick();
         checks++;
         if (imem_addr !== m_pc || instr_d !== m_instr || pc_d !== m_pcd || pc_plus4_d !== m_pc4 ||
             valid_d !== m_valid || halted !== m_halt || fetch_count !== exp_cnt16() ||
             fetch_count_s !== exp_cnt2() || imem_addr_s !== m_pc) begin
            errors++;
            $display("FAIL random[%0d]: addr=%h instr=%h pc_d=%h pc4=%h v=%b h=%b cnt=%0d cnt_s=%0d, required %h %h %h %h %b %b %0d %0d",
                     i, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted, fetch_count, fetch_count_s,
                     m_pc, m_instr, m_pcd, m_pc4, m_valid, m_halt, exp_cnt16(), exp_cnt2());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = i + 1;
      m_pc = 0; m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_boot = 1; m_halt = 0; m_cnt = 0;
      test_reset();
      test_startup();
      test_stall();
      test_redirect();
      test_halt();
      test_flush_wrap();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
